// File: rtl/hood_mode_timer.sv
// rtl/hood_mode_timer.sv - hurricane/self-clean countdown with BCD time digits and expiry mode requests
// Optional blink output guarded by HOOD_TIMER_WARN_EN.
module hood_mode_timer #(
  parameter int CLK_HZ        = 100000000,
  parameter int HURRICANE_SEC = 60,
  parameter int CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_on,
  input  logic [2:0] mode_state,
  output logic [7:0] remain_sec,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens_bcd,
  output logic [3:0] sec_ones_bcd,
  output logic       timer_active,
  output logic       timeout_req,
  output logic [2:0] timeout_mode,
  output logic       hurricane_used,
`ifdef HOOD_TIMER_WARN_EN
  output logic       warn,
`endif
  output logic       hurricane_denied
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0] HURR_LEN  = 8'(HURRICANE_SEC);
  localparam logic [7:0] CLEAN_LEN = 8'(CLEAN_SEC);

  localparam logic [2:0] MODE_STBY  = 3'b000;
  localparam logic [2:0] MODE_L2    = 3'b010;
  localparam logic [2:0] MODE_HURR  = 3'b011;
  localparam logic [2:0] MODE_CLEAN = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN_HURR, RUN_CLEAN, EXPIRE} state_t;

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [2:0]    prev_mode;
  logic [7:0]    remain_n;
  logic          used_n;
  logic          denied_n;
  logic [2:0]    tmode_n;
  logic          tick;
  logic          mode_changed;
  logic [2:0]    run_mode;

`ifdef HOOD_TIMER_WARN_EN
  // Blink phase is tied to parity of remain_sec so it reads 1 at 10, 0 at 9, ...
  localparam logic HURR_WARN0  = (HURRICANE_SEC <= 10) && (HURRICANE_SEC % 2 == 0);
  localparam logic CLEAN_WARN0 = (CLEAN_SEC <= 10) && (CLEAN_SEC % 2 == 0);
  logic warn_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      presc_q          <= '0;
      prev_mode        <= MODE_STBY;
      remain_sec       <= 8'd0;
      hurricane_used   <= 1'b0;
      hurricane_denied <= 1'b0;
      timeout_mode     <= MODE_STBY;
`ifdef HOOD_TIMER_WARN_EN
      warn             <= 1'b0;
`endif
    end else begin
      state_q          <= state_n;
      presc_q          <= presc_n;
      prev_mode        <= mode_state;
      remain_sec       <= remain_n;
      hurricane_used   <= used_n;
      hurricane_denied <= denied_n;
      timeout_mode     <= tmode_n;
`ifdef HOOD_TIMER_WARN_EN
      warn             <= warn_n;
`endif
    end
  end

  always_comb begin
    state_n      = state_q;
    presc_n      = presc_q;
    remain_n     = remain_sec;
    used_n       = hurricane_used;
    denied_n     = 1'b0;
    tmode_n      = timeout_mode;
`ifdef HOOD_TIMER_WARN_EN
    warn_n       = warn;
`endif
    tick         = (presc_q == PRESC_MAX);
    mode_changed = (mode_state != prev_mode);
    run_mode     = (state_q == RUN_HURR) ? MODE_HURR : MODE_CLEAN;

    if (!machine_on) begin
      state_n  = IDLE;
      presc_n  = '0;
      remain_n = 8'd0;
      used_n   = 1'b0;
`ifdef HOOD_TIMER_WARN_EN
      warn_n   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mode_changed && mode_state == MODE_HURR) begin
            if (hurricane_used) begin
              denied_n = 1'b1;
            end else begin
              state_n  = RUN_HURR;
              remain_n = HURR_LEN;
              used_n   = 1'b1;
              presc_n  = '0;
`ifdef HOOD_TIMER_WARN_EN
              warn_n   = HURR_WARN0;
`endif
            end
          end else if (mode_changed && mode_state == MODE_CLEAN) begin
            state_n  = RUN_CLEAN;
            remain_n = CLEAN_LEN;
            presc_n  = '0;
`ifdef HOOD_TIMER_WARN_EN
            warn_n   = CLEAN_WARN0;
`endif
          end
        end
        RUN_HURR, RUN_CLEAN: begin
          // Leaving the run mode aborts even on the cycle of the final tick.
          if (mode_state != run_mode) begin
            state_n  = IDLE;
            presc_n  = '0;
            remain_n = 8'd0;
`ifdef HOOD_TIMER_WARN_EN
            warn_n   = 1'b0;
`endif
          end else if (tick) begin
            presc_n = '0;
            if (remain_sec == 8'd1) begin
              remain_n = 8'd0;
              state_n  = EXPIRE;
              tmode_n  = (state_q == RUN_HURR) ? MODE_L2 : MODE_STBY;
`ifdef HOOD_TIMER_WARN_EN
              warn_n   = 1'b0;
`endif
            end else begin
              remain_n = remain_sec - 8'd1;
`ifdef HOOD_TIMER_WARN_EN
              if (remain_sec == 8'd11)
                warn_n = 1'b1;
              else if (remain_sec <= 8'd10)
                warn_n = ~warn;
`endif
            end
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
        EXPIRE:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign timer_active = (state_q == RUN_HURR) || (state_q == RUN_CLEAN);
  assign timeout_req  = (state_q == EXPIRE);

  // BCD split by range compare; the ones digit uses 4-bit wraparound subtraction.
  logic [7:0] rem60;
  logic [3:0] tens_off;
  always_comb begin
    min_bcd      = 4'd0;
    rem60        = remain_sec;
    sec_tens_bcd = 4'd0;
    tens_off     = 4'd0;
    if (remain_sec >= 8'd240) begin
      min_bcd = 4'd4; rem60 = remain_sec - 8'd240;
    end else if (remain_sec >= 8'd180) begin
      min_bcd = 4'd3; rem60 = remain_sec - 8'd180;
    end else if (remain_sec >= 8'd120) begin
      min_bcd = 4'd2; rem60 = remain_sec - 8'd120;
    end else if (remain_sec >= 8'd60) begin
      min_bcd = 4'd1; rem60 = remain_sec - 8'd60;
    end
    if (rem60 >= 8'd50) begin
      sec_tens_bcd = 4'd5; tens_off = 4'd2;
    end else if (rem60 >= 8'd40) begin
      sec_tens_bcd = 4'd4; tens_off = 4'd8;
    end else if (rem60 >= 8'd30) begin
      sec_tens_bcd = 4'd3; tens_off = 4'd14;
    end else if (rem60 >= 8'd20) begin
      sec_tens_bcd = 4'd2; tens_off = 4'd4;
    end else if (rem60 >= 8'd10) begin
      sec_tens_bcd = 4'd1; tens_off = 4'd10;
    end
    sec_ones_bcd = rem60[3:0] - tens_off;
  end

endmodule
